// File: rtl/upb_cam_pkg.sv
// Shared definitions for the CAM management path: entry geometry, AXI response codes,
// the commit request record and the write/read FSM state types.
package upb_cam_pkg;

    localparam int unsigned CAM_ENTRY_W    = 256;
    localparam int unsigned CAM_WORD_W     = 32;
    localparam int unsigned CAM_WORD_OFS_W = 3;
    // Widest entry index that still fits a 32-bit byte address above the word offset.
    localparam int unsigned CAM_IDX_W_MAX  = 27;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [CAM_IDX_W_MAX-1:0] addr;
        logic [CAM_ENTRY_W-1:0]   data;
    } cam_wr_req_t;

    typedef enum logic [1:0] {
        WrIdle,
        WrWrite,
        WrCommit,
        WrResp
    } wr_state_e;

    typedef enum logic {
        RdIdle,
        RdData
    } rd_state_e;

    // Legal when every bit above the entry index is zero and the access is word aligned.
    function automatic logic axil_addr_legal(input logic [31:0] addr, input int unsigned idx_w);
        logic [31:0] upper;
        upper = addr >> (idx_w + 32'd5);
        return (upper == 32'd0) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/upb_axil_wr_capture.sv
// AXI4-Lite write address / write data capture. AW and W are taken independently, in
// either order or together, and held until the owner consumes them with clear.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   accept_en          owner will be able to take a new beat in the coming cycle
//   clear              owner consumes both captured beats this cycle
//   awvalid/awready    write address handshake, awaddr captured into aw_addr
//   wvalid/wready      write data handshake, wdata/wstrb captured into w_data/w_strb
//   aw_captured        an address beat is held
//   w_captured         a data beat is held
module upb_axil_wr_capture (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        accept_en,
    input  logic        clear,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        aw_captured,
    output logic        w_captured,
    output logic [31:0] aw_addr,
    output logic [31:0] w_data,
    output logic [3:0]  w_strb
);

    logic        aw_cap_q, aw_cap_d;
    logic        w_cap_q, w_cap_d;
    logic        awready_q, awready_d;
    logic        wready_q, wready_d;
    logic [31:0] aw_addr_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;
    logic        aw_hs, w_hs;

    assign aw_hs = awvalid && awready_q;
    assign w_hs  = wvalid && wready_q;

    always_comb begin
        aw_cap_d = aw_cap_q | aw_hs;
        w_cap_d  = w_cap_q | w_hs;
        if (clear) begin
            aw_cap_d = 1'b0;
            w_cap_d  = 1'b0;
        end
        // Readies are registered so they sit low while reset is asserted.
        awready_d = accept_en && !aw_cap_d;
        wready_d  = accept_en && !w_cap_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_cap_q  <= 1'b0;
            w_cap_q   <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_addr_q <= 32'd0;
            w_data_q  <= 32'd0;
            w_strb_q  <= 4'd0;
        end else begin
            aw_cap_q  <= aw_cap_d;
            w_cap_q   <= w_cap_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            if (aw_hs) begin
                aw_addr_q <= awaddr;
            end
            if (w_hs) begin
                w_data_q <= wdata;
                w_strb_q <= wstrb;
            end
        end
    end

    assign awready     = awready_q;
    assign wready      = wready_q;
    assign aw_captured = aw_cap_q;
    assign w_captured  = w_cap_q;
    assign aw_addr     = aw_addr_q;
    assign w_data      = w_data_q;
    assign w_strb      = w_strb_q;

endmodule

// File: rtl/upb_cam_axi_write_slave.sv
// AXI4-Lite management slave for the BRAM CAM. Host word writes addressed as
// {entry index, word offset} are merged into a 256-bit staging buffer; the write of the
// last word commits the whole buffer to the CAM write port under the last word's index.
// Reads return the staged word at the addressed offset.
// Ports:
//   s_axi_aclk, s_axi_aresetn   clock, asynchronous active-low reset
//   s_axi_aw*, s_axi_w*, s_axi_b*  AXI4-Lite write channels (prot ignored)
//   s_axi_ar*, s_axi_r*            AXI4-Lite read channels (prot ignored)
//   cam_wr_en/cam_wr_ready         commit request, held until the CAM accepts it
//   cam_wr_addr, cam_wr_data       commit index and full staged entry
module upb_cam_axi_write_slave
    import upb_cam_pkg::*;
#(
    parameter int unsigned CAM_DEPTH   = 2048,
    parameter int unsigned IDX_W       = $clog2(CAM_DEPTH),
    parameter int unsigned ENTRY_WORDS = 8
) (
    input  logic                   s_axi_aclk,
    input  logic                   s_axi_aresetn,
    input  logic                   s_axi_awvalid,
    output logic                   s_axi_awready,
    input  logic [31:0]            s_axi_awaddr,
    input  logic [2:0]             s_axi_awprot,
    input  logic                   s_axi_wvalid,
    output logic                   s_axi_wready,
    input  logic [31:0]            s_axi_wdata,
    input  logic [3:0]             s_axi_wstrb,
    output logic                   s_axi_bvalid,
    input  logic                   s_axi_bready,
    output logic [1:0]             s_axi_bresp,
    input  logic                   s_axi_arvalid,
    output logic                   s_axi_arready,
    input  logic [31:0]            s_axi_araddr,
    input  logic [2:0]             s_axi_arprot,
    output logic                   s_axi_rvalid,
    input  logic                   s_axi_rready,
    output logic [31:0]            s_axi_rdata,
    output logic [1:0]             s_axi_rresp,
    output logic                   cam_wr_en,
    input  logic                   cam_wr_ready,
    output logic [IDX_W-1:0]       cam_wr_addr,
    output logic [CAM_ENTRY_W-1:0] cam_wr_data
);

    localparam logic [CAM_WORD_OFS_W-1:0] LAST_OFS = CAM_WORD_OFS_W'(ENTRY_WORDS - 1);

    // ---------------------------------------------------------------- write path
    wr_state_e              wr_state_q, wr_state_d;
    logic [CAM_ENTRY_W-1:0] staging_q, staging_d;
    logic [1:0]             bresp_q, bresp_d;
    logic [IDX_W-1:0]       cam_addr_q, cam_addr_d;

    logic                      aw_cap, w_cap;
    logic [31:0]               aw_addr_cap, w_data_cap;
    logic [3:0]                w_strb_cap;
    logic                      cap_clear, accept_en;
    logic [CAM_WORD_OFS_W-1:0] wr_ofs;
    logic [IDX_W-1:0]          wr_idx;
    logic                      wr_legal;

    assign cap_clear = (wr_state_q == WrIdle) && aw_cap && w_cap;
    assign accept_en = (wr_state_d == WrIdle);

    upb_axil_wr_capture u_capture (
        .clk         (s_axi_aclk),
        .rst_n       (s_axi_aresetn),
        .accept_en   (accept_en),
        .clear       (cap_clear),
        .awvalid     (s_axi_awvalid),
        .awready     (s_axi_awready),
        .awaddr      (s_axi_awaddr),
        .wvalid      (s_axi_wvalid),
        .wready      (s_axi_wready),
        .wdata       (s_axi_wdata),
        .wstrb       (s_axi_wstrb),
        .aw_captured (aw_cap),
        .w_captured  (w_cap),
        .aw_addr     (aw_addr_cap),
        .w_data      (w_data_cap),
        .w_strb      (w_strb_cap)
    );

    assign wr_ofs   = aw_addr_cap[4:2];
    assign wr_idx   = aw_addr_cap[IDX_W+4:5];
    assign wr_legal = axil_addr_legal(aw_addr_cap, IDX_W);

    always_comb begin
        wr_state_d = wr_state_q;
        staging_d  = staging_q;
        bresp_d    = bresp_q;
        cam_addr_d = cam_addr_q;
        case (wr_state_q)
            WrIdle: begin
                if (cap_clear) begin
                    wr_state_d = WrWrite;
                end
            end
            WrWrite: begin
                if (wr_legal) begin
                    for (int b = 0; b < 4; b++) begin
                        if (w_strb_cap[b]) begin
                            staging_d[{wr_ofs, 5'd0} + 8 * b +: 8] = w_data_cap[8 * b +: 8];
                        end
                    end
                    bresp_d = AXI_RESP_OKAY;
                    // The commit index comes only from the last-word write; earlier words
                    // carry no tag of their own.
                    if (wr_ofs == LAST_OFS) begin
                        cam_addr_d = wr_idx;
                        wr_state_d = WrCommit;
                    end else begin
                        wr_state_d = WrResp;
                    end
                end else begin
                    bresp_d    = AXI_RESP_SLVERR;
                    wr_state_d = WrResp;
                end
            end
            WrCommit: begin
                if (cam_wr_ready) begin
                    wr_state_d = WrResp;
                end
            end
            WrResp: begin
                if (s_axi_bready) begin
                    wr_state_d = WrIdle;
                end
            end
            default: wr_state_d = WrIdle;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            wr_state_q <= WrIdle;
            staging_q  <= '0;
            bresp_q    <= AXI_RESP_OKAY;
            cam_addr_q <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            staging_q  <= staging_d;
            bresp_q    <= bresp_d;
            cam_addr_q <= cam_addr_d;
        end
    end

    cam_wr_req_t cam_req;
    assign cam_req.addr = CAM_IDX_W_MAX'(cam_addr_q);
    assign cam_req.data = staging_q;

    assign s_axi_bvalid = (wr_state_q == WrResp);
    assign s_axi_bresp  = bresp_q;
    // Commit outputs come straight from registers, so they stay stable while stalled.
    assign cam_wr_en    = (wr_state_q == WrCommit);
    assign cam_wr_addr  = cam_req.addr[IDX_W-1:0];
    assign cam_wr_data  = cam_req.data;

    // ----------------------------------------------------------------- read path
    rd_state_e   rd_state_q, rd_state_d;
    logic        arready_q, arready_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        ar_hs;

    assign ar_hs = s_axi_arvalid && arready_q;

    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            RdIdle: begin
                if (ar_hs) begin
                    rd_state_d = RdData;
                    // Sampled from the registered buffer: a same-cycle write is not visible.
                    if (axil_addr_legal(s_axi_araddr, IDX_W)) begin
                        rdata_d = staging_q[{s_axi_araddr[4:2], 5'd0} +: 32];
                        rresp_d = AXI_RESP_OKAY;
                    end else begin
                        rdata_d = 32'd0;
                        rresp_d = AXI_RESP_SLVERR;
                    end
                end
            end
            RdData: begin
                if (s_axi_rready) begin
                    rd_state_d = RdIdle;
                end
            end
            default: rd_state_d = RdIdle;
        endcase
        arready_d = (rd_state_d == RdIdle);
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            rd_state_q <= RdIdle;
            arready_q  <= 1'b0;
            rdata_q    <= 32'd0;
            rresp_q    <= AXI_RESP_OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            arready_q  <= arready_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = (rd_state_q == RdData);
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;

    logic unused_bits;
    assign unused_bits = ^{s_axi_awprot, s_axi_arprot, cam_req.addr[CAM_IDX_W_MAX-1:IDX_W]};

endmodule

// File: tb/tb_upb_cam_axi_write_slave.sv
module tb_upb_cam_axi_write_slave;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    localparam logic [31:0] W0 = 32'h0BAD_F00D;
    localparam logic [31:0] W1 = 32'hDEAD_BEEF;
    localparam logic [31:0] W2 = 32'hCAFE_0002;
    localparam logic [31:0] W3 = 32'h1122_3344;
    localparam logic [31:0] W4 = 32'h4444_0004;
    localparam logic [31:0] W5 = 32'h5555_0005;
    localparam logic [31:0] W6 = 32'h6666_0006;
    localparam logic [31:0] W7 = 32'h7777_0007;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         awvalid = 1'b0, awready;
    logic [31:0]  awaddr = '0;
    logic [2:0]   awprot = '0;
    logic         wvalid = 1'b0, wready;
    logic [31:0]  wdata = '0;
    logic [3:0]   wstrb = '0;
    logic         bvalid, bready = 1'b1;
    logic [1:0]   bresp;
    logic         arvalid = 1'b0, arready;
    logic [31:0]  araddr = '0;
    logic [2:0]   arprot = '0;
    logic         rvalid, rready = 1'b1;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         cam_wr_en, cam_wr_ready = 1'b1;
    logic [10:0]  cam_wr_addr;
    logic [255:0] cam_wr_data;

    int n_vec  = 0;
    int n_fail = 0;

    int           commit_cnt = 0;
    logic [10:0]  last_addr = '0;
    logic [255:0] last_data = '0;

    always #5 clk = ~clk;

    upb_cam_axi_write_slave dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_awaddr  (awaddr),
        .s_axi_awprot  (awprot),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_bresp   (bresp),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_araddr  (araddr),
        .s_axi_arprot  (arprot),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .cam_wr_en     (cam_wr_en),
        .cam_wr_ready  (cam_wr_ready),
        .cam_wr_addr   (cam_wr_addr),
        .cam_wr_data   (cam_wr_data)
    );

    // Commit monitor: records every accepted commit.
    always @(posedge clk) begin
        if (cam_wr_en && cam_wr_ready) begin
            commit_cnt <= commit_cnt + 1;
            last_addr  <= cam_wr_addr;
            last_data  <= cam_wr_data;
        end
    end

    typedef struct {
        logic        is_read;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        int          exp_lat;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_fail++;
        $display("FAIL %s: timed out waiting for handshake", name);
    endtask

    // Presents AW and W (AW delayed by aw_delay cycles); returns just after the later handshake.
    task automatic send_aw_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_delay);
        bit aw_pend, w_pend, aw_fire, w_fire;
        int cyc;
        aw_pend = 1'b1;
        w_pend  = 1'b1;
        cyc     = 0;
        awaddr  = a;
        wdata   = d;
        wstrb   = s;
        wvalid  = 1'b1;
        while ((aw_pend || w_pend) && cyc < 100) begin
            if (cyc == aw_delay) awvalid = 1'b1;
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            @(posedge clk); #1;
            cyc++;
            if (aw_fire) begin
                aw_pend = 1'b0;
                awvalid = 1'b0;
            end
            if (w_fire) begin
                w_pend = 1'b0;
                wvalid = 1'b0;
            end
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        if (aw_pend || w_pend) timeout("aw/w handshake");
    endtask

    // Counts edges from the last handshake edge until bvalid; completes the response.
    task automatic wait_b(output logic [1:0] resp, output int lat);
        lat  = 0;
        resp = 2'bxx;
        while (!bvalid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (bvalid) begin
            resp = bresp;
            @(posedge clk); #1;
        end else begin
            timeout("bvalid");
        end
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                           output int lat);
        bit fire, done;
        int cyc;
        done    = 1'b0;
        cyc     = 0;
        araddr  = a;
        arvalid = 1'b1;
        while (!done && cyc < 100) begin
            fire = arready;
            @(posedge clk); #1;
            cyc++;
            if (fire) done = 1'b1;
        end
        arvalid = 1'b0;
        lat  = 0;
        d    = 'x;
        resp = 2'bxx;
        if (!done) begin
            timeout("ar handshake");
        end else begin
            while (!rvalid && lat < 100) begin
                @(posedge clk); #1;
                lat++;
            end
            if (rvalid) begin
                d    = rdata;
                resp = rresp;
                @(posedge clk); #1;
            end else begin
                timeout("rvalid");
            end
        end
    endtask

    logic [1:0]   resp;
    logic [31:0]  rd;
    int           lat;
    int           cyc;
    int           cnt_before;
    logic [255:0] e1, e2, e3;

    initial begin
        // Test 1 burst, test 4 illegal accesses, test 5 partial strobe.
        vecs.push_back('{1'b0, 32'h9620, W0, 4'hF, OKAY, 32'h0, 2, "t1 w0"});
        vecs.push_back('{1'b0, 32'h9624, W1, 4'hF, OKAY, 32'h0, 2, "t1 w1"});
        vecs.push_back('{1'b0, 32'h9628, W2, 4'hF, OKAY, 32'h0, 2, "t1 w2"});
        vecs.push_back('{1'b0, 32'h962C, W3, 4'hF, OKAY, 32'h0, 2, "t1 w3"});
        vecs.push_back('{1'b0, 32'h9630, W4, 4'hF, OKAY, 32'h0, 2, "t1 w4"});
        vecs.push_back('{1'b0, 32'h9634, W5, 4'hF, OKAY, 32'h0, 2, "t1 w5"});
        vecs.push_back('{1'b0, 32'h9638, W6, 4'hF, OKAY, 32'h0, 2, "t1 w6"});
        vecs.push_back('{1'b0, 32'h963C, W7, 4'hF, OKAY, 32'h0, 3, "t1 w7 commit"});
        vecs.push_back('{1'b1, 32'h962C, 32'h0, 4'h0, OKAY, W3, 0, "rd w3"});
        vecs.push_back('{1'b1, 32'h963C, 32'h0, 4'h0, OKAY, W7, 0, "rd w7"});
        vecs.push_back('{1'b0, 32'h0010_0000, 32'hFFFF_FFFF, 4'hF, SLVERR, 32'h0, 2, "t4 wr oor"});
        vecs.push_back('{1'b0, 32'h9623, 32'hFFFF_FFFF, 4'hF, SLVERR, 32'h0, 2, "wr unaligned"});
        vecs.push_back('{1'b1, 32'h9624, 32'h0, 4'h0, OKAY, W1, 0, "t4 rd w1"});
        vecs.push_back('{1'b1, 32'h9620, 32'h0, 4'h0, OKAY, W0, 0, "rd w0 unchanged"});
        vecs.push_back('{1'b1, 32'h0010_0000, 32'h0, 4'h0, SLVERR, 32'h0, 0, "rd oor"});
        vecs.push_back('{1'b1, 32'h9622, 32'h0, 4'h0, SLVERR, 32'h0, 0, "rd unaligned"});
        vecs.push_back('{1'b0, 32'h962C, 32'hAABB_CCDD, 4'b0101, OKAY, 32'h0, 2, "t5 wr strb"});
        // Bytes 0 and 2 replaced: 11 BB 33 DD.
        vecs.push_back('{1'b1, 32'h962C, 32'h0, 4'h0, OKAY, 32'h11BB_33DD, 0, "t5 rd strb"});
        // Staged words carry no index: another index sees the same word.
        vecs.push_back('{1'b1, 32'h002C, 32'h0, 4'h0, OKAY, 32'h11BB_33DD, 0, "rd untagged"});

        e1 = {W7, W6, W5, W4, W3, W2, W1, W0};
        e2 = {W7, W6, W5, W4, 32'h11BB_33DD, 32'h2222_2222, W1, W0};
        e3 = {32'h7070_7070, W6, W5, W4, 32'h11BB_33DD, 32'h2222_2222, W1, W0};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst awready", awready, 1'b0);
        check("rst wready", wready, 1'b0);
        check("rst arready", arready, 1'b0);
        check("rst bvalid", bvalid, 1'b0);
        check("rst rvalid", rvalid, 1'b0);
        check("rst resp/rdata", {bresp, rresp, rdata}, 36'd0);
        check("rst cam_wr_en", cam_wr_en, 1'b0);
        check("rst cam_wr_addr", cam_wr_addr, 11'd0);
        check("rst cam_wr_data", cam_wr_data, 256'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            if (vecs[i].is_read) begin
                do_read(vecs[i].addr, rd, resp, lat);
                check({vecs[i].name, " rresp"}, resp, vecs[i].exp_resp);
                check({vecs[i].name, " rdata"}, rd, vecs[i].exp_rdata);
                check({vecs[i].name, " rlat"}, lat, vecs[i].exp_lat);
            end else begin
                send_aw_w(vecs[i].addr, vecs[i].data, vecs[i].strb, 0);
                wait_b(resp, lat);
                check({vecs[i].name, " bresp"}, resp, vecs[i].exp_resp);
                check({vecs[i].name, " blat"}, lat, vecs[i].exp_lat);
            end
        end
        check("t1 commit count", commit_cnt, 1);
        check("t1 commit addr", last_addr, 11'h4B1);
        check("t1 commit data", last_data, e1);

        // Test 2: W three cycles ahead of AW.
        send_aw_w(32'h9628, 32'h2222_2222, 4'hF, 3);
        wait_b(resp, lat);
        check("t2 bresp", resp, OKAY);
        check("t2 blat", lat, 2);
        do_read(32'h9628, rd, resp, lat);
        check("t2 rd w2", rd, 32'h2222_2222);

        // Word 7 with no strobes still commits the unchanged word.
        send_aw_w(32'h963C, 32'hFFFF_FFFF, 4'h0, 0);
        wait_b(resp, lat);
        check("strb0 bresp", resp, OKAY);
        check("strb0 blat", lat, 3);
        check("strb0 commit count", commit_cnt, 2);
        check("strb0 commit addr", last_addr, 11'h4B1);
        check("strb0 commit data", last_data, e2);

        // Test 3: CAM stalls the commit for five cycles; response held by bready low.
        cam_wr_ready = 1'b0;
        bready       = 1'b0;
        send_aw_w(32'h9A3C, 32'h7070_7070, 4'hF, 0);
        cyc = 0;
        while (!cam_wr_en && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("t3 en latency", cyc, 2);
        for (int k = 0; k < 6; k++) begin
            check("t3 en held", cam_wr_en, 1'b1);
            check("t3 addr held", cam_wr_addr, 11'h4D1);
            check("t3 data held", cam_wr_data, e3);
            check("t3 no accept", {awready, wready, bvalid}, 3'b000);
            if (k == 5) cam_wr_ready = 1'b1;
            @(posedge clk); #1;
        end
        check("t3 en dropped", cam_wr_en, 1'b0);
        check("t3 bvalid after accept", bvalid, 1'b1);
        check("t3 bresp", bresp, OKAY);
        repeat (2) begin
            @(posedge clk); #1;
            check("t3 bvalid hold", {bvalid, bresp}, {1'b1, OKAY});
            check("t3 no accept in resp", {awready, wready}, 2'b00);
        end
        bready = 1'b1;
        @(posedge clk); #1;
        check("t3 bvalid cleared", bvalid, 1'b0);
        check("t3 commit count", commit_cnt, 3);
        check("t3 commit addr", last_addr, 11'h4D1);

        // Test 6: reset while the commit is stalled.
        cam_wr_ready = 1'b0;
        cnt_before   = commit_cnt;
        send_aw_w(32'h963C, 32'h1234_5678, 4'hF, 0);
        cyc = 0;
        while (!cam_wr_en && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("t6 en before reset", cam_wr_en, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t6 en in reset", cam_wr_en, 1'b0);
        check("t6 bvalid in reset", bvalid, 1'b0);
        check("t6 data in reset", cam_wr_data, 256'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n        = 1'b1;
        cam_wr_ready = 1'b1;
        @(posedge clk); #1;
        do_read(32'h9620, rd, resp, lat);
        check("t6 rd w0 rresp", resp, OKAY);
        check("t6 rd w0", rd, 32'd0);
        do_read(32'h963C, rd, resp, lat);
        check("t6 rd w7", rd, 32'd0);
        check("t6 no commit", commit_cnt, cnt_before);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
